// File: rtl/turf_rdwr_wb_bridge.sv
// Bridges the UDP en/wr/ack control port onto one Wishbone classic cycle, with a bus timeout.
// Optional `TURF_RDWR_BRIDGE_STATS_EN adds a saturating error counter on err_count_o.
module turf_rdwr_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        en_i,
    input  logic        wr_i,
    input  logic [27:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [27:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
`ifdef TURF_RDWR_BRIDGE_STATS_EN
    output logic [15:0] err_count_o,
`endif
    input  logic [31:0] wb_dat_i
);

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef TURF_RDWR_BRIDGE_STATS_EN
    logic [CW-1:0] errcnt_q, errcnt_d;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            cnt_q    <= '0;
`ifdef TURF_RDWR_BRIDGE_STATS_EN
            errcnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            cnt_q    <= cnt_d;
`ifdef TURF_RDWR_BRIDGE_STATS_EN
            errcnt_q <= errcnt_d;
`endif
        end
    end

    // Completion priority inside BUS: slave ack, then slave error, then timeout.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    we_d    = wr_i;
                    adr_d   = adr_i;
                    wdat_d  = dat_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = cnt_q + CW'(1);
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) rdat_d = wb_dat_i;
                end else if (wb_err_i || (cnt_q == CNT_LAST)) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) rdat_d = TIMEOUT_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

`ifdef TURF_RDWR_BRIDGE_STATS_EN
    // Counts alongside err_o so the new value is visible with the error pulse.
    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && (errcnt_q != '1)) errcnt_d = errcnt_q + CW'(1);
    end
    assign err_count_o = errcnt_q;
`endif

    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign dat_o    = rdat_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign wb_sel_o = 4'hF;

endmodule
